multiplicador_param: RTL and testbench

Parametrised sequential shift-and-add multiplier with its own control FSM, start/done handshake, signed/unsigned mode and optional early termination. It is the next generation of the team's 8-bit multiplier datapath: width is generic and the block needs no external controller. It sits between operand registers and any consumer that can tolerate a multi-cycle, one-operation-at-a-time latency.

---
 rtl/multiplicador_pkg.sv | 16 +
 rtl/multiplicador_datapath_param.sv | 50 +++++
 rtl/multiplicador_param.sv | 98 +++++++++
 tb/tb_multiplicador_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared types for the parametrised shift-and-add multiplier.
// Holds the control-state encoding and the iteration-counter sizing helper.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Wide enough to hold any iteration count from 0 up to WIDTH.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplicador_datapath_param.sv
// Accumulator, shifted multiplicand and shifted multiplier registers.
// rq_zero_o looks one shift ahead so the controller can stop on the same edge.
module multiplicador_datapath_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     p_mag_i,
    input  logic [WIDTH-1:0]     q_mag_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 rq_zero_o
);

    logic [2*WIDTH-1:0] a_q,  a_d;
    logic [2*WIDTH-1:0] rp_q, rp_d;
    logic [WIDTH-1:0]   rq_q, rq_d;

    always_comb begin
        a_d  = a_q;
        rp_d = rp_q;
        rq_d = rq_q;
        if (load_i) begin
            a_d  = '0;
            rp_d = {{WIDTH{1'b0}}, p_mag_i};
            rq_d = q_mag_i;
        end else if (step_i) begin
            a_d  = a_q + (rp_q & {2*WIDTH{rq_q[0]}});
            rp_d = {rp_q[2*WIDTH-2:0], 1'b0};
            rq_d = {1'b0, rq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            rp_q <= '0;
            rq_q <= '0;
        end else begin
            a_q  <= a_d;
            rp_q <= rp_d;
            rq_q <= rq_d;
        end
    end

    assign acc_o     = a_q;
    assign rq_zero_o = (rq_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/multiplicador_param.sv
// Sequential signed/unsigned multiplier with start/done handshake.
// Operands are reduced to magnitudes on load; the sign is reapplied once at FINISH.
module multiplicador_param
    import multiplicador_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   m
);

    localparam int CW = count_width(WIDTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 sign_q,  sign_d;
    logic [2*WIDTH-1:0]   m_q,     m_d;
    logic                 done_q,  done_d;
    logic                 load, step, rq_zero;
    logic [WIDTH-1:0]     p_mag, q_mag;
    logic [2*WIDTH-1:0]   acc;

    // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    assign p_mag = (signed_mode && p[WIDTH-1]) ? -p : p;
    assign q_mag = (signed_mode && q[WIDTH-1]) ? -q : q;

    multiplicador_datapath_param #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .p_mag_i   (p_mag),
        .q_mag_i   (q_mag),
        .acc_o     (acc),
        .rq_zero_o (rq_zero)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sign_d  = sign_q;
        m_d     = m_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    sign_d  = signed_mode & (p[WIDTH-1] ^ q[WIDTH-1]);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step    = 1'b1;
                count_d = count_q + CW'(1);
                if ((count_q == CW'(WIDTH - 1)) || ((EARLY_EXIT != 0) && rq_zero))
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                m_d     = sign_q ? -acc : acc;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sign_q  <= 1'b0;
            m_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            m_q     <= m_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign m    = m_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Bench for multiplicador_param: three instances (8-bit full-width, 8-bit early-exit,
// 16-bit early-exit) checked against an integer-arithmetic reference.
module tb_multiplicador_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start8e, start16, sm;
    logic [15:0] p_b, q_b;

    logic        busy8, done8, busy8e, done8e, busy16, done16;
    logic [15:0] m8, m8e;
    logic [31:0] m16;

    int          sel;
    logic        busy_s, done_s;
    logic [31:0] m_s;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    multiplicador_param #(.WIDTH(8), .EARLY_EXIT(0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm),
        .p(p_b[7:0]), .q(q_b[7:0]), .busy(busy8), .done(done8), .m(m8));

    multiplicador_param #(.WIDTH(8), .EARLY_EXIT(1)) dut8e (
        .clk(clk), .rst(rst), .start(start8e), .signed_mode(sm),
        .p(p_b[7:0]), .q(q_b[7:0]), .busy(busy8e), .done(done8e), .m(m8e));

    multiplicador_param #(.WIDTH(16), .EARLY_EXIT(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm),
        .p(p_b), .q(q_b), .busy(busy16), .done(done16), .m(m16));

    always_comb begin
        busy_s = busy8;
        done_s = done8;
        m_s    = {16'h0, m8};
        case (sel)
            1: begin busy_s = busy8e; done_s = done8e; m_s = {16'h0, m8e}; end
            2: begin busy_s = busy16; done_s = done16; m_s = m16; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand value as a mathematical integer under the selected interpretation.
    function automatic longint sval(input int w, input bit smode, input logic [15:0] x);
        longint v;
        v = longint'(x) & ((64'sd1 <<< w) - 1);
        if (smode && x[w-1]) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    function automatic logic [31:0] ref_prod(input int w, input bit smode,
                                             input logic [15:0] pa, input logic [15:0] qa);
        longint pr;
        pr = sval(w, smode, pa) * sval(w, smode, qa);
        return 32'(pr & ((64'sd1 <<< (2 * w)) - 1));
    endfunction

    function automatic int ref_n(input int w, input bit ee, input bit smode, input logic [15:0] qa);
        longint mag;
        int     n;
        if (!ee) return w;
        mag = sval(w, smode, qa);
        if (mag < 0) mag = -mag;
        n = 1;
        for (int i = 0; i < w; i++)
            if (mag[i]) n = i + 1;
        return n;
    endfunction

    task automatic launch(input int s, input bit smode, input logic [15:0] pa, input logic [15:0] qa);
        sel = s;
        sm  = smode;
        p_b = pa;
        q_b = qa;
        start8  = (s == 0);
        start8e = (s == 1);
        start16 = (s == 2);
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start8e = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_s) return;
            if (!busy_s) busy_ok = 1'b0;
        end
        lat = -1;
    endtask

    task automatic check_result(input string tag, input int s, input bit smode,
                                input logic [15:0] pa, input logic [15:0] qa,
                                input int lat, input bit busy_ok);
        int w;
        w = (s == 2) ? 16 : 8;
        chk({tag, "_m"},    64'(m_s), 64'(ref_prod(w, smode, pa, qa)));
        chk({tag, "_lat"},  64'(lat), 64'(ref_n(w, s != 0, smode, qa) + 1));
        chk({tag, "_busy"}, 64'({busy_ok, busy_s}), 64'(2'b10));
    endtask

    task automatic run_check(input string tag, input int s, input bit smode,
                             input logic [15:0] pa, input logic [15:0] qa);
        int lat;
        bit bok;
        @(negedge clk);
        launch(s, smode, pa, qa);
        wait_done(0, lat, bok);
        check_result(tag, s, smode, pa, qa, lat, bok);
    endtask

    initial begin
        int lat;
        bit bok;
        logic [15:0] rp, rq;
        bit rs;

        rst = 1'b1; sel = 0; sm = 1'b0; p_b = '0; q_b = '0;
        start8 = 1'b0; start8e = 1'b0; start16 = 1'b0;
        #12;
        chk("rst_out8",  64'({busy8, done8, m8}), 64'(0));
        chk("rst_out16", 64'({busy16, done16, m16}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        run_check("u13x11",    0, 1'b0, 16'd13,   16'd11);
        run_check("s_m128sq",  0, 1'b1, 16'h0080, 16'h0080);
        run_check("s_m128x127",0, 1'b1, 16'h0080, 16'h007F);
        chk("c080", 64'(m8), 64'(16'hC080));
        run_check("ee255x3",   1, 1'b0, 16'd255,  16'd3);
        run_check("ee_q0",     1, 1'b0, 16'd77,   16'd0);
        run_check("ee_sneg",   1, 1'b1, 16'h00FD, 16'h00FE);

        // Back-to-back: second start lands in the done cycle of the first.
        run_check("uFFxFF",    0, 1'b0, 16'hFF,   16'hFF);
        launch(0, 1'b0, 16'd2, 16'd3);
        wait_done(0, lat, bok);
        check_result("b2b", 0, 1'b0, 16'd2, 16'd3, lat, bok);

        // start pulsed while running must not disturb the operation.
        @(negedge clk);
        launch(0, 1'b0, 16'd100, 16'd37);
        repeat (3) @(posedge clk);
        #1;
        p_b = 16'd5; q_b = 16'd7; sm = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        sm = 1'b0; p_b = 16'd100; q_b = 16'd37;
        wait_done(4, lat, bok);
        check_result("midstart", 0, 1'b0, 16'd100, 16'd37, lat, bok);

        // Reset mid-run clears outputs at once.
        @(negedge clk);
        launch(0, 1'b0, 16'd200, 16'd100);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out", 64'({busy8, done8, m8}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_check("after_rst", 0, 1'b0, 16'd200, 16'd100);

        for (int i = 0; i < 12; i++) begin
            rp = 16'($urandom); rq = 16'($urandom_range(0, 255) >> $urandom_range(0, 7));
            rs = 1'($urandom);
            run_check("rnd8e", 1, rs, rp & 16'hFF, rq);
        end
        for (int i = 0; i < 40; i++) begin
            rp = 16'($urandom); rq = 16'($urandom) >> $urandom_range(0, 15);
            rs = 1'($urandom);
            run_check("rnd16", 2, rs, rp, rq);
        end
        run_check("s16_min", 2, 1'b1, 16'h8000, 16'h8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
